latch_bank_reader: RTL and testbench

//  Read-side controller for a bank of latch-based storage words (LASX/LARX-style cells).

---
 rtl/latch_bank_reader_if.sv | 33 +++
 rtl/latch_bank_reader.sv | 163 ++++++++++++++++
 tb/tb_latch_bank_reader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/latch_bank_reader_if.sv
// Bundle between the latch-bank read controller and its neighbours.
// Carries the run request (start/start_addr/count), the bank read port
// (rd_en/rd_addr/rd_data), the bit-serial output (so/so_valid/so_ready/so_last)
// and the run status (busy/done).
// slave  : the reader itself.
// master : the requester, latch bank and serial consumer side.
interface latch_bank_reader_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
);
    logic             start;
    logic [AW-1:0]    start_addr;
    logic [AW:0]      count;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             so;
    logic             so_valid;
    logic             so_ready;
    logic             so_last;
    logic             busy;
    logic             done;

    modport slave (
        input  start, start_addr, count, rd_data, so_ready,
        output rd_en, rd_addr, so, so_valid, so_last, busy, done
    );

    modport master (
        output start, start_addr, count, rd_data, so_ready,
        input  rd_en, rd_addr, so, so_valid, so_last, busy, done
    );
endinterface

// File: rtl/latch_bank_reader.sv
// Read-side controller for a latch-based storage bank. Reads a contiguous,
// wrapping run of words and shifts each one out MSB first over a valid/ready
// serial port. rd_en tells the write side to keep the latch clocks low.
// Ports:
//   clk   rising-edge clock
//   rstb  asynchronous active-low reset
//   bus   latch_bank_reader_if.slave (request, bank read port, serial out, status)
module latch_bank_reader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              rstb,
    latch_bank_reader_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        LOAD  = 3'd2,
        SHIFT = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [AW-1:0]    addr, addr_n;
    logic [CW-1:0]    words, words_n;       // words left, including the one in flight
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             rd_en, rd_en_n;
    logic [AW-1:0]    rd_addr, rd_addr_n;
    logic             so, so_n;
    logic             so_valid, so_valid_n;
    logic             so_last, so_last_n;
    logic             busy, busy_n;
    logic             done, done_n;
    logic [CW-1:0]    count_clamped;
    logic [AW-1:0]    addr_inc;

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= IDLE;
            addr     <= '0;
            words    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            so       <= 1'b0;
            so_valid <= 1'b0;
            so_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            words    <= words_n;
            bit_cnt  <= bit_n;
            shreg    <= shreg_n;
            rd_en    <= rd_en_n;
            rd_addr  <= rd_addr_n;
            so       <= so_n;
            so_valid <= so_valid_n;
            so_last  <= so_last_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // Next state, datapath and next output values.
    always_comb begin
        state_n    = state;
        addr_n     = addr;
        words_n    = words;
        bit_n      = bit_cnt;
        shreg_n    = shreg;
        rd_en_n    = rd_en;
        rd_addr_n  = rd_addr;
        so_n       = so;
        so_valid_n = so_valid;
        so_last_n  = so_last;
        busy_n     = busy;
        done_n     = 1'b0;

        count_clamped = (bus.count > CW'(DEPTH)) ? CW'(DEPTH) : bus.count;
        addr_inc      = addr + AW'(1);    // wraps DEPTH-1 -> 0

        case (state)
            IDLE: begin
                if (bus.start) begin
                    busy_n  = 1'b1;
                    words_n = count_clamped;
                    addr_n  = bus.start_addr;
                    if (count_clamped == '0) begin
                        state_n = FIN;
                        done_n  = 1'b1;
                    end else begin
                        state_n   = ADDR;
                        rd_en_n   = 1'b1;
                        rd_addr_n = bus.start_addr;
                    end
                end
            end
            ADDR: begin
                state_n = LOAD;
            end
            LOAD: begin
                // Bank data is valid this cycle; capture it and present the MSB.
                state_n    = SHIFT;
                rd_en_n    = 1'b0;
                shreg_n    = bus.rd_data;
                so_n       = bus.rd_data[WIDTH-1];
                so_valid_n = 1'b1;
                so_last_n  = 1'b0;
                bit_n      = '0;
            end
            SHIFT: begin
                if (bus.so_ready) begin
                    if (bit_cnt == BW'(WIDTH - 1)) begin
                        so_valid_n = 1'b0;
                        so_n       = 1'b0;
                        so_last_n  = 1'b0;
                        if (words > CW'(1)) begin
                            state_n   = ADDR;
                            words_n   = words - CW'(1);
                            addr_n    = addr_inc;
                            rd_addr_n = addr_inc;
                            rd_en_n   = 1'b1;
                        end else begin
                            state_n = FIN;
                            words_n = '0;
                            done_n  = 1'b1;
                        end
                    end else begin
                        shreg_n   = shreg << 1;
                        so_n      = shreg_n[WIDTH-1];
                        bit_n     = bit_cnt + BW'(1);
                        so_last_n = (words == CW'(1)) && (bit_cnt == BW'(WIDTH - 2));
                    end
                end
            end
            FIN: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.rd_en    = rd_en;
    assign bus.rd_addr  = rd_addr;
    assign bus.so       = so;
    assign bus.so_valid = so_valid;
    assign bus.so_last  = so_last;
    assign bus.busy     = busy;
    assign bus.done     = done;
endmodule

// File: tb/tb_latch_bank_reader.sv
// Self-checking bench for latch_bank_reader: a latch-bank model feeds rd_data,
// expected serial bits and read addresses are queued when each run is launched
// and compared as the DUT produces them.
module tb_latch_bank_reader;
    localparam int unsigned W = 8;
    localparam int unsigned D = 16;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk;
    logic rstb;
    logic toggle_ready;
    logic [W-1:0] bank [D];

    exp_t       exp_q[$];
    logic [3:0] addr_q[$];

    int n_tests;
    int n_fail;

    logic prev_stall;
    logic prev_so;
    logic prev_rd;
    logic prev_valid;
    int   rd_len;
    int   gap;

    latch_bank_reader_if #(.WIDTH(W), .AW(4)) bus ();

    latch_bank_reader #(.WIDTH(W), .DEPTH(D)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Latch bank: data appears the cycle after rd_en.
    initial begin
        bus.rd_data = '0;
        forever begin
            @(posedge clk);
            bus.rd_data <= bus.rd_en ? bank[bus.rd_addr] : '0;
        end
    end

    // Consumer ready: constant 1 or toggling each cycle.
    initial begin
        bus.so_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.so_ready = toggle_ready ? ~bus.so_ready : 1'b1;
        end
    end

    // Monitor: serial bits, stall stability, read addresses, rd_en width, inter-word gap.
    always @(negedge clk) begin
        if (!rstb) begin
            prev_stall = 1'b0;
            prev_rd    = 1'b0;
            prev_valid = 1'b0;
            rd_len     = 0;
            gap        = 0;
        end else begin
            if (bus.so_valid && bus.so_ready) begin
                if (exp_q.size() == 0) begin
                    check("so_unexpected", 32'(bus.so_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("so_bit", 32'(bus.so), 32'(e.b));
                    check("so_last", 32'(bus.so_last), 32'(e.last));
                end
            end
            if (bus.so_valid) check("rd_en_in_shift", 32'(bus.rd_en), 32'd0);
            if (bus.so_last && !bus.so_valid) check("so_last_no_valid", 32'(bus.so_last), 32'd0);
            if (prev_stall) check("stall_hold", 32'({bus.so_valid, bus.so}), 32'({1'b1, prev_so}));
            prev_stall = bus.so_valid && !bus.so_ready;
            prev_so    = bus.so;

            if (bus.rd_en && !prev_rd) begin
                if (addr_q.size() == 0) check("rd_unexpected", 32'(bus.rd_en), 32'd0);
                else check("rd_addr", 32'(bus.rd_addr), 32'(addr_q.pop_front()));
            end
            if (bus.rd_en) rd_len++;
            else if (prev_rd) begin
                check("rd_en_len", 32'(rd_len), 32'd2);
                rd_len = 0;
            end
            prev_rd = bus.rd_en;

            if (bus.so_valid && !prev_valid && bus.busy) check("word_gap", 32'(gap), 32'd2);
            if (!bus.busy || bus.so_valid) gap = 0;
            else gap++;
            prev_valid = bus.so_valid;
        end
    end

    task automatic push_expected(input logic [3:0] sa, input logic [4:0] cnt);
        int n;
        logic [3:0] a;
        n = (cnt > 5'd16) ? 16 : int'(cnt);
        for (int w = 0; w < n; w++) begin
            a = sa + 4'(w);
            addr_q.push_back(a);
            for (int b = W - 1; b >= 0; b--) begin
                exp_t e;
                e.b    = bank[a][b];
                e.last = (w == n - 1) && (b == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    // Launch a run and check DONE latency (exp_lat < 0 skips it) and BUSY/DONE shape.
    task automatic run(input logic [3:0] sa, input logic [4:0] cnt, input bit hold, input int exp_lat);
        int  lat;
        bit  found;
        push_expected(sa, cnt);
        @(posedge clk);
        #1;
        bus.start_addr = sa;
        bus.count      = cnt;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
        lat   = 0;
        found = 1'b0;
        for (int i = 1; i <= 2000 && !found; i++) begin
            @(negedge clk);
            if (bus.done) begin
                found = 1'b1;
                lat   = i;
            end
        end
        if (!found) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            if (exp_lat >= 0) check("done_lat", 32'(lat), 32'(exp_lat));
            check("busy_at_done", 32'(bus.busy), 32'd1);
            bus.start = 1'b0;
            @(negedge clk);
            check("done_pulse", 32'(bus.done), 32'd0);
            check("busy_after", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        toggle_ready   = 1'b0;
        rstb           = 1'b0;
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.count      = '0;
        for (int i = 0; i < int'(D); i++) bank[i] = W'($urandom_range(0, 255));
        bank[3] = 8'hA5;
        bank[5] = 8'h81;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({bus.rd_en, bus.rd_addr, bus.so, bus.so_valid,
                                    bus.so_last, bus.busy, bus.done}), 32'd0);
        @(negedge clk);
        rstb = 1'b1;

        // Single word, documented bit pattern and DONE at k+11.
        run(4'd3, 5'd1, 1'b0, 11);
        // Wrapping run 15,0,1.
        run(4'd15, 5'd3, 1'b0, 31);
        // Stalling consumer on 0x81.
        toggle_ready = 1'b1;
        run(4'd5, 5'd1, 1'b0, -1);
        toggle_ready = 1'b0;
        repeat (2) @(posedge clk);
        // Empty run and clamped oversize run.
        run(4'd7, 5'd0, 1'b0, 1);
        run(4'd0, 5'd20, 1'b0, 161);
        // START held through a run: only one run.
        run(4'd4, 5'd2, 1'b1, 21);
        repeat (5) @(negedge clk);
        check("idle_after_hold", 32'(bus.busy), 32'd0);
        run(4'd8, 5'd1, 1'b0, 11);

        // Reset during the second word's shift.
        push_expected(4'd2, 5'd4);
        @(posedge clk);
        #1;
        bus.start_addr = 4'd2;
        bus.count      = 5'd4;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_shift", 32'({bus.busy, bus.so_valid}), 32'h3);
        rstb = 1'b0;
        #1;
        check("abort_outputs", 32'({bus.rd_en, bus.rd_addr, bus.so, bus.so_valid,
                                    bus.so_last, bus.busy, bus.done}), 32'd0);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", 32'({bus.done, bus.busy}), 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        run(4'd11, 5'd2, 1'b0, 21);

        repeat (3) @(negedge clk);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("addr_q_empty", 32'(addr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
